// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED sequencer. It holds the mode encodings, the
// register offsets inside the 4-byte window, the FSM state type and small
// helper functions.
// Optional feature macro: LED_SEQ_PWM_EN. When it is defined, mode 11 is PWM
// and its entry state is RUN_A. Otherwise mode 11 behaves as mode 00.
// -----------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_STATIC = 2'd1,
        ST_RUN_A  = 2'd2,
        ST_RUN_B  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_CHASE  = 2'b10;
    localparam logic [1:0] MODE_PWM    = 2'b11;

    localparam logic [1:0] OFF_PATTERN = 2'd0;
    localparam logic [1:0] OFF_CTRL    = 2'd1;
    localparam logic [1:0] OFF_PERIOD  = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT = 2;

    // This is the state that the FSM enters when a sequence restarts with the
    // given CTRL value.
    function automatic state_t entry_state(input logic [2:0] ctrl);
        state_t s;
        if (!ctrl[CTRL_EN_BIT]) begin
            s = ST_OFF;
        end else begin
            case (ctrl[1:0])
                MODE_BLINK: s = ST_RUN_A;
                MODE_CHASE: s = ST_RUN_A;
`ifdef LED_SEQ_PWM_EN
                MODE_PWM:   s = ST_RUN_A;
`endif
                default:    s = ST_STATIC;
            endcase
        end
        return s;
    endfunction

    // This rotates the pattern left by one position. Bit 3 wraps to bit 0.
    function automatic logic [3:0] rotl1(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

endpackage

// File: rtl/led_seq_tick.sv
// -----------------------------------------------------------------------------
// led_seq_tick
// This is a free-running prescaler. It asserts tick for one clk cycle out of
// every PRESCALE cycles. The first tick comes PRESCALE cycles after reset is
// released.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - one-cycle step tick
// -----------------------------------------------------------------------------
module led_seq_tick #(
    parameter int PRESCALE = 25000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
// This is a memory-mapped LED sequencer with four byte registers at BASE_ADDR:
//   +0 PATTERN[3:0]
//   +1 CTRL (bits [1:0] mode, bit 2 enable)
//   +2 PERIOD[7:0]
//   +3 STATUS (read-only)
// The modes are static, blink, chase, and PWM when that option is enabled.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   Abus     - CPU address bus (16 bits)
//   Data_In  - CPU write data (8 bits)
//   we       - write strobe, active high
//   Data_Out - combinational read data (8 bits). It is 0 when the address does
//              not hit the window.
//   LEDs     - registered LED drive (4 bits)
// Optional feature macro: LED_SEQ_PWM_EN. It enables PWM in mode 11 and adds
// the 4-bit phase counter that PWM needs.
// -----------------------------------------------------------------------------
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hD018,
    parameter int          PRESCALE  = 25000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Abus,
    input  logic [7:0]  Data_In,
    input  logic        we,
    output logic [7:0]  Data_Out,
    output logic [3:0]  LEDs
);

    logic        hit;
    logic [1:0]  offset;
    logic        wr;
    logic        restart;
    logic        tick;
    logic        step;
    logic [7:0]  eff_period;

    logic [3:0]  pattern_reg, pattern_next;
    logic [2:0]  ctrl_reg, ctrl_next;
    logic [7:0]  period_reg, period_next;
    logic [7:0]  step_cnt_reg, step_cnt_next;
    logic [3:0]  work_reg, work_next;
    logic [3:0]  leds_reg, leds_next;
    state_t      state_reg, state_next;

    assign hit    = (Abus[15:2] == BASE_ADDR[15:2]);
    assign offset = Abus[1:0];
    assign wr     = we && hit;

    led_seq_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

`ifdef LED_SEQ_PWM_EN
    logic [3:0] phase_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_reg + 1'b1;
        end
    end
`endif

    // Register write decode. A write to STATUS is dropped.
    always_comb begin
        pattern_next = pattern_reg;
        ctrl_next    = ctrl_reg;
        period_next  = period_reg;
        restart      = 1'b0;
        if (wr) begin
            case (offset)
                OFF_PATTERN: begin
                    pattern_next = Data_In[3:0];
                    restart      = 1'b1;
                end
                OFF_CTRL: begin
                    ctrl_next = Data_In[2:0];
                    restart   = 1'b1;
                end
                OFF_PERIOD: period_next = Data_In;
                default: ;
            endcase
        end
    end

    // The step compare uses >=. If PERIOD is lowered below the current count,
    // the next tick still fires a step and the counter does not run past it.
    assign eff_period = (period_reg == 8'd0) ? 8'd1 : period_reg;
    assign step       = tick && (({1'b0, step_cnt_reg} + 9'd1) >= {1'b0, eff_period});

    always_comb begin
        step_cnt_next = step_cnt_reg;
        if (restart) begin
            step_cnt_next = '0;
        end else if (tick) begin
            step_cnt_next = step ? 8'd0 : step_cnt_reg + 8'd1;
        end
    end

    // FSM next state and working pattern. A restart takes priority over a step
    // in the same cycle.
    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        if (restart) begin
            state_next = entry_state(ctrl_next);
            work_next  = pattern_next;
        end else if (step) begin
            case (state_reg)
                ST_RUN_A: begin
                    if (ctrl_reg[1:0] == MODE_BLINK) begin
                        state_next = ST_RUN_B;
                    end else if (ctrl_reg[1:0] == MODE_CHASE) begin
                        work_next = rotl1(work_reg);
                    end
                end
                ST_RUN_B: state_next = ST_RUN_A;
                default: ;
            endcase
        end
    end

    // The LED value is computed from the post-edge state. LEDs therefore
    // follow the causing write or step with exactly one clk of latency.
    always_comb begin
        leds_next = 4'b0000;
        case (state_next)
            ST_STATIC: leds_next = pattern_next;
            ST_RUN_A: begin
                if (ctrl_next[1:0] == MODE_CHASE) begin
                    leds_next = work_next;
`ifdef LED_SEQ_PWM_EN
                end else if (ctrl_next[1:0] == MODE_PWM) begin
                    leds_next = (phase_reg < period_next[3:0]) ? pattern_next : 4'b0000;
`endif
                end else begin
                    leds_next = pattern_next;
                end
            end
            default: leds_next = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_reg  <= '0;
            ctrl_reg     <= '0;
            period_reg   <= '0;
            step_cnt_reg <= '0;
            work_reg     <= '0;
            leds_reg     <= '0;
            state_reg    <= ST_OFF;
        end else begin
            pattern_reg  <= pattern_next;
            ctrl_reg     <= ctrl_next;
            period_reg   <= period_next;
            step_cnt_reg <= step_cnt_next;
            work_reg     <= work_next;
            leds_reg     <= leds_next;
            state_reg    <= state_next;
        end
    end

    assign LEDs = leds_reg;

    always_comb begin
        Data_Out = 8'h00;
        if (hit) begin
            case (offset)
                OFF_PATTERN: Data_Out = {4'b0000, pattern_reg};
                OFF_CTRL:    Data_Out = {5'b00000, ctrl_reg};
                OFF_PERIOD:  Data_Out = period_reg;
                default:     Data_Out = {2'b00, state_reg, leds_reg};
            endcase
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_seq_ctrl
// This is a self-checking bench for led_seq_ctrl with PRESCALE=4. A
// behavioural model tracks the registers, the number of clk edges since reset,
// the step count, the blink phase and the chase rotation. The bench checks
// Data_Out before every edge and LEDs after every edge. The directed scenarios
// come first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_led_seq_ctrl;

    localparam logic [15:0] BASE = 16'hD018;
    localparam int          PRE  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] abus = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic        we = 1'b0;
    logic [7:0]  dout;
    logic [3:0]  leds;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    led_seq_ctrl #(.BASE_ADDR(BASE), .PRESCALE(PRE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Abus     (abus),
        .Data_In  (din),
        .we       (we),
        .Data_Out (dout),
        .LEDs     (leds)
    );

    // Reference model state
    int         m_k;     // clk edges since reset release
    int         m_sc;    // ticks counted toward the next step
    logic [3:0] m_pat;
    logic [2:0] m_ctrl;
    logic [7:0] m_per;
    bit         m_on;    // blink: 1 means the pattern is shown
    int         m_rot;   // chase: number of left rotations since restart
    logic [3:0] m_led;

`ifdef LED_SEQ_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] p, input int r);
        logic [3:0] v = p;
        for (int i = 0; i < (r % 4); i++) v = {v[2:0], v[3]};
        return v;
    endfunction

    function automatic logic [3:0] model_leds(input int phase);
        if (!m_ctrl[2]) return 4'b0000;
        case (m_ctrl[1:0])
            2'b00: return m_pat;
            2'b01: return m_on ? m_pat : 4'b0000;
            2'b10: return rotl(m_pat, m_rot);
            default: begin
                if (!PWM) return m_pat;
                return (phase < int'(m_per[3:0])) ? m_pat : 4'b0000;
            end
        endcase
    endfunction

    function automatic logic [1:0] model_code();
        if (!m_ctrl[2]) return 2'd0;
        case (m_ctrl[1:0])
            2'b00: return 2'd1;
            2'b01: return m_on ? 2'd2 : 2'd3;
            2'b10: return 2'd2;
            default: return PWM ? 2'd2 : 2'd1;
        endcase
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (a[15:2] != BASE[15:2]) return 8'h00;
        case (a[1:0])
            2'd0: return {4'h0, m_pat};
            2'd1: return {5'h00, m_ctrl};
            2'd2: return m_per;
            default: return {2'b00, model_code(), m_led};
        endcase
    endfunction

    task automatic model_reset();
        m_k = 0; m_sc = 0; m_pat = '0; m_ctrl = '0; m_per = '0;
        m_on = 1'b1; m_rot = 0; m_led = '0;
    endtask

    // The model advances by one clk edge using the inputs that are present
    // before that edge.
    task automatic model_edge(input bit w, input logic [15:0] a, input logic [7:0] d);
        int  phase = m_k % 16;
        bit  tick  = ((m_k % PRE) == PRE - 1);
        bit  step  = 1'b0;
        bit  rs    = 1'b0;
        int  per   = (m_per == 0) ? 1 : int'(m_per);
        m_k++;
        if (tick) begin
            if (m_sc + 1 >= per) begin step = 1'b1; m_sc = 0; end
            else m_sc++;
        end
        if (w && a[15:2] == BASE[15:2]) begin
            case (a[1:0])
                2'd0: begin m_pat = d[3:0]; rs = 1'b1; end
                2'd1: begin m_ctrl = d[2:0]; rs = 1'b1; end
                2'd2: m_per = d;
                default: ;
            endcase
        end
        if (rs) begin
            m_sc = 0; m_on = 1'b1; m_rot = 0;
        end else if (step && m_ctrl[2]) begin
            if (m_ctrl[1:0] == 2'b01) m_on = ~m_on;
            else if (m_ctrl[1:0] == 2'b10) m_rot++;
        end
        m_led = model_leds(phase);
    endtask

    // One bus cycle. The task drives the inputs, checks read data, lets one
    // edge pass, then checks LEDs.
    task automatic cycle(input bit w, input logic [15:0] a, input logic [7:0] d);
        we = w; abus = a; din = d;
        #1;
        check("rdata", dout, model_read(a));
        model_edge(w, a, d);
        @(posedge clk);
        #1;
        check("leds", {4'h0, leds}, {4'h0, m_led});
        if (w) $display("wr  addr=%04h data=%02h -> leds=%b (model %b)", a, d, leds, m_led);
        we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; we = 1'b0; abus = 16'h0000; din = 8'h00;
        #2;
        check("rst_leds", {4'h0, leds}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, BASE + 16'(i % 4), 8'h00);
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // Reset state: all registers read zero and the LEDs are off.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, BASE + 16'(i), 8'h00);
            check("rst_read", dout, 8'h00);
        end

        // Static mode. The LEDs follow the CTRL write by one clk.
        cycle(1'b1, BASE + 16'd0, 8'h05);
        cycle(1'b1, BASE + 16'd1, 8'h04);
        check("static_leds", {4'h0, leds}, 8'h05);
        abus = BASE + 16'd3; #1;
        check("status", dout, 8'h15);

        // Blink: PERIOD=2 with PRESCALE=4 gives a toggle every 8 clk.
        cycle(1'b1, BASE + 16'd2, 8'h02);
        cycle(1'b1, BASE + 16'd0, 8'h03);
        cycle(1'b1, BASE + 16'd1, 8'h05);
        idle(40);

        // Chase: PATTERN 1001 rotated once every 4 clk.
        cycle(1'b1, BASE + 16'd2, 8'h01);
        cycle(1'b1, BASE + 16'd0, 8'h09);
        cycle(1'b1, BASE + 16'd1, 8'h06);
        idle(24);

        // A PATTERN write on the cycle a step fires. The write wins and the
        // sequence restarts from the new pattern.
        for (int i = 0; i < 8 && (m_k % PRE) != PRE - 1; i++) cycle(1'b0, 16'h0000, 8'h00);
        cycle(1'b1, BASE + 16'd0, 8'h03);
        check("step_vs_write", {4'h0, leds}, 8'h03);
        idle(12);

        // Mode 11. This is PWM when the option is built, otherwise static.
        cycle(1'b1, BASE + 16'd0, 8'h0F);
        cycle(1'b1, BASE + 16'd2, 8'h04);
        cycle(1'b1, BASE + 16'd1, 8'h07);
        idle(40);

        // Randomized traffic, with one reset in the middle of a sequence.
        for (int it = 0; it < 600; it++) begin
            int r = $urandom_range(0, 9);
            logic [15:0] a;
            logic [7:0]  d;
            if (it == 300) do_reset();
            if (r < 2) begin
                int off = $urandom_range(0, 3);
                a = BASE + 16'(off);
                case (off)
                    0: d = 8'($urandom_range(0, 255));
                    1: d = 8'($urandom_range(0, 7));
                    2: d = 8'($urandom_range(0, 3));
                    default: d = 8'($urandom_range(0, 255));
                endcase
                cycle(1'b1, a, d);
            end else if (r == 2) begin
                a = 16'($urandom);
                if (a[15:2] == BASE[15:2]) a[15] = ~a[15];
                cycle(1'b1, a, 8'($urandom));
            end else begin
                a = (r < 6) ? BASE + 16'($urandom_range(0, 3)) : 16'($urandom);
                cycle(1'b0, a, 8'h00);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
